// File: rtl/registro_n.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// registro_n
// Parameterized N-bit edge-triggered storage register with load enable and
// synchronous active-high reset. The datapath's basic state element: the
// input word is captured on a rising clock edge when enable is high, and
// the stored value is held otherwise.
//
// Parameters:
//   N            data width in bits (N >= 1)
//   RESET_VALUE  value loaded into the register by reset
//
// Ports (declaration order matters for positional instantiation):
//   z       out  N  registered value, driven straight from the storage flops
//   clock   in   1  single clock, all state changes on its rising edge
//   enable  in   1  load enable, active-high
//   inval   in   N  data to load
//   reset   in   1  synchronous, active-high reset (wins over enable)
//   valid   out  1  only when REGISTRO_VALID_EN is defined; high once the
//                   register holds loaded data, cleared by reset
//
// Build option:
//   REGISTRO_VALID_EN  adds the valid output and its flop. z behaves the
//                      same in both builds.
// -----------------------------------------------------------------------------
module registro_n #(
  parameter int             N           = 32,
  parameter logic [N-1:0]   RESET_VALUE = '0
) (
  output logic [N-1:0] z,
  input  logic         clock,
  input  logic         enable,
  input  logic [N-1:0] inval,
  input  logic         reset
`ifdef REGISTRO_VALID_EN
  ,
  output logic         valid
`endif
);

  logic [N-1:0] z_reg;
  logic [N-1:0] z_next;

  // Priority: reset, then load, then hold. No power-on value is given to
  // z_reg; it stays unknown until the first reset or load.
  always_comb begin
    z_next = z_reg;
    if (reset) begin
      z_next = RESET_VALUE;
    end else if (enable) begin
      z_next = inval;
    end
  end

  always_ff @(posedge clock) begin
    z_reg <= z_next;
  end

  // Output comes only from the flops, so nothing on the inputs can reach z
  // between edges.
  assign z = z_reg;

`ifdef REGISTRO_VALID_EN
  logic valid_reg;
  logic valid_next;

  // Sticky flag: set by the first load, cleared only by reset.
  always_comb begin
    valid_next = valid_reg;
    if (reset) begin
      valid_next = 1'b0;
    end else if (enable) begin
      valid_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    valid_reg <= valid_next;
  end

  assign valid = valid_reg;
`endif

endmodule

// File: tb/tb_registro_n.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_registro_n
// Self-checking bench for registro_n. Two instances run side by side:
//   u1 : N = 1, default RESET_VALUE
//   u8 : N = 8, RESET_VALUE = 8'hA5
// Each step drives inputs just after a falling edge, pushes the expected
// register contents into per-instance queues, and pops/compares them half a
// nanosecond after the following rising edge. Clock period is 2 ns.
// -----------------------------------------------------------------------------
module tb_registro_n;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk = 1'b0;
  logic       rst1, en1;
  logic [0:0] in1;
  logic [0:0] z1;
  logic       rst8, en8;
  logic [7:0] in8;
  logic [7:0] z8;
`ifdef REGISTRO_VALID_EN
  logic       valid1, valid8;
`endif

  int tests  = 0;
  int errors = 0;

  // Reference model state (unknown until first reset/load)
  logic [0:0] m1;
  logic [7:0] m8;
  logic       mv8;

  // Scoreboard queues
  logic [0:0] q1[$];
  logic [7:0] q8[$];
  logic       qv8[$];

  always #1 clk = ~clk;

  registro_n #(.N(1)) u1 (
    .z(z1), .clock(clk), .enable(en1), .inval(in1), .reset(rst1)
`ifdef REGISTRO_VALID_EN
    , .valid(valid1)
`endif
  );

  registro_n #(.N(8), .RESET_VALUE(RV8)) u8 (
    .z(z8), .clock(clk), .enable(en8), .inval(in8), .reset(rst8)
`ifdef REGISTRO_VALID_EN
    , .valid(valid8)
`endif
  );

  // glitch: 0 none, 1 drop inval of u1 mid-cycle and restore it,
  //         2 short reset pulse on both instances that never spans an edge
  task automatic step(input string name,
                      input logic r1, input logic e1, input logic [0:0] d1,
                      input logic r8, input logic e8, input logic [7:0] d8,
                      input int glitch);
    logic [0:0] x1;
    logic [7:0] x8;
    logic       xv;
    @(negedge clk);
    rst1 = r1; en1 = e1; in1 = d1;
    rst8 = r8; en8 = e8; in8 = d8;
    if (r1) m1 = 1'b0; else if (e1) m1 = d1;
    if (r8) begin m8 = RV8; mv8 = 1'b0; end
    else if (e8) begin m8 = d8; mv8 = 1'b1; end
    q1.push_back(m1);
    q8.push_back(m8);
    qv8.push_back(mv8);
    if (glitch == 1) begin
      #0.3 in1 = ~d1;
      #0.3 in1 = d1;
    end else if (glitch == 2) begin
      #0.2 rst1 = 1'b1; rst8 = 1'b1;
      #0.4 rst1 = r1;   rst8 = r8;
    end
    @(posedge clk);
    #0.5;
    x1 = q1.pop_front();
    x8 = q8.pop_front();
    xv = qv8.pop_front();
    tests++;
    if (z1 !== x1) begin
      errors++;
      $display("[TB] FAIL %s z1: got %b expected %b", name, z1, x1);
    end
    tests++;
    if (z8 !== x8) begin
      errors++;
      $display("[TB] FAIL %s z8: got %h expected %h", name, z8, x8);
    end
`ifdef REGISTRO_VALID_EN
    tests++;
    if (valid8 !== xv) begin
      errors++;
      $display("[TB] FAIL %s valid8: got %b expected %b", name, valid8, xv);
    end
`endif
    $display("[TB] %s: z1=%b z8=%h", name, z1, z8);
  endtask

  task automatic test_reset();
    step("reset", 1, 0, 1, 1, 0, 8'hFF, 0);
    step("reset_hold", 0, 0, 1, 0, 0, 8'h00, 0);
  endtask

  task automatic test_hold_n1();
    for (int i = 0; i < 3; i++) step("hold_en0", 0, 0, 1, 0, 0, 8'h00, 0);
    step("load_n1", 0, 1, 1, 0, 0, 8'h00, 0);
  endtask

  task automatic test_inval_glitch();
    step("inval_glitch", 0, 1, 1, 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step("hold_one", 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic test_reset_priority();
    step("load_3c", 0, 0, 0, 0, 1, 8'h3C, 0);
    step("reset_after_load", 0, 0, 0, 1, 0, 8'h3C, 0);
    step("load_3c_again", 0, 0, 0, 0, 1, 8'h3C, 0);
    step("reset_and_load", 0, 0, 0, 1, 1, 8'hFF, 0);
    step("load_after_reset", 0, 0, 0, 0, 1, 8'h77, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) begin
      logic [7:0] v;
      v = 8'(i);
      step("b2b", 0, 1, 1'(i), 0, 1, v, 0);
    end
  endtask

  task automatic test_valid();
    step("valid_reset", 0, 0, 0, 1, 0, 8'h00, 0);
    step("valid_load", 0, 0, 0, 0, 1, 8'h10, 0);
    for (int i = 0; i < 5; i++) step("valid_hold", 0, 0, 0, 0, 0, 8'hEE, 0);
    step("valid_clear", 0, 0, 0, 1, 0, 8'h00, 0);
  endtask

  task automatic test_reset_glitch();
    step("pre_glitch_load", 0, 1, 1, 0, 1, 8'h5A, 0);
    step("reset_glitch", 0, 0, 0, 0, 0, 8'h00, 2);
    step("post_glitch", 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  initial begin
    rst1 = 1'b0; en1 = 1'b0; in1 = 1'b0;
    rst8 = 1'b0; en8 = 1'b0; in8 = 8'h00;
    m1 = 'x; m8 = 'x; mv8 = 1'b0;
    test_reset();
    test_hold_n1();
    test_inval_glitch();
    test_reset_priority();
    test_back_to_back();
    test_valid();
    test_reset_glitch();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #5000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
